// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between
// the CPU datapath (port 0) and the program/data loader (port 1).
//
// Round-robin arbitration by default. Defining DMEM_ARB_FIXED_PRI_EN
// gives port 0 fixed priority and removes the last-grant pointer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pK_req            port K request, held until pK_gnt
//   pK_we             port K write (1) / read (0)
//   pK_addr, pK_wdata port K address / write data
//   pK_gnt            port K grant pulse (request consumed)
//   pK_rvalid         port K read data valid (cycle after grant)
//   pK_rdata          port K read data (0 when not valid)
//   mem_en, mem_we    memory enable / write enable
//   mem_addr          memory address
//   mem_wdata         memory write data
//   mem_rdata         memory read data, one cycle after an enabled read
module dmem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_BITS-1:0]  p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_BITS-1:0]  p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rv0_q, rv0_d;
  logic                  rv1_q, rv1_d;
  logic                  elig0, elig1;

`ifndef DMEM_ARB_FIXED_PRI_EN
  // Last port granted; reset to 1 so port 0 wins first contention.
  logic                  ptr_q, ptr_d;
`endif

  // A port granted this cycle has had its request consumed.
  assign elig0 = p0_req && (state_q != GNT0);
  assign elig1 = p1_req && (state_q != GNT1);

  always_comb begin
    state_d = IDLE;
`ifdef DMEM_ARB_FIXED_PRI_EN
    if (elig0) begin
      state_d = GNT0;
    end else if (elig1) begin
      state_d = GNT1;
    end
`else
    ptr_d = ptr_q;
    if (elig0 && elig1) begin
      state_d = ptr_q ? GNT0 : GNT1;
    end else if (elig0) begin
      state_d = GNT0;
    end else if (elig1) begin
      state_d = GNT1;
    end
    if (state_d == GNT0) begin
      ptr_d = 1'b0;
    end else if (state_d == GNT1) begin
      ptr_d = 1'b1;
    end
`endif

    // Address/data hold their last values while idle.
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == GNT0) begin
      we_d    = p0_we;
      addr_d  = p0_addr;
      wdata_d = p0_wdata;
    end else if (state_d == GNT1) begin
      we_d    = p1_we;
      addr_d  = p1_addr;
      wdata_d = p1_wdata;
    end

    // Read data returns the cycle after a read grant.
    rv0_d = (state_q == GNT0) && !we_q;
    rv1_d = (state_q == GNT1) && !we_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRI_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
`ifndef DMEM_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign p0_gnt    = (state_q == GNT0);
  assign p1_gnt    = (state_q == GNT1);
  assign mem_en    = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata  = rv0_q ? mem_rdata : '0;
  assign p1_rdata  = rv1_q ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters.
- Port 0 is the CPU datapath (loadR/storeR accesses); port 1 is the program/data loader (memory initialisation, debug readback).
- Registered round-robin arbitration, one transaction per grant, fixed 1-cycle read latency.
- Sits between the datapath/loader and the data memory instance.

Parameters:
- DATA_WIDTH, 8, data word width.
- ADDR_BITS, 5, data memory address width (32 words).

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- p0_req  in  1  port 0 request; held high until p0_gnt seen
- p0_we  in  1  port 0 write (1) / read (0), stable while p0_req
- p0_addr  in  ADDR_BITS  port 0 address
- p0_wdata  in  DATA_WIDTH  port 0 write data
- p0_gnt  out  1  port 0 granted; 1-cycle pulse, request consumed
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DATA_WIDTH  port 0 read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_BITS  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after an mem_en read

Behaviour:
- Reset: sync active-high. While rst=1 at a posedge:
  - state=IDLE; all gnt, rvalid, mem_en, mem_we = 0.
  - mem_addr, mem_wdata = 0.
  - last-grant pointer = 1, so port 0 wins the first contention.
- Reset mid-transaction: the pending rvalid is dropped; no memory write occurs in the cycle after reset.
- FSM states: IDLE, GNT0, GNT1. The state holds the grant issued this cycle.
- Decision at each posedge (not in reset):
  - Eligible requests: req_k=1, excluding the port granted in the current cycle (its request is consumed even though req is still high).
  - None eligible -> IDLE.
  - One eligible -> grant it.
  - Both eligible -> grant the port opposite the last-grant pointer.
  - Any grant updates the pointer.
- In GNTk (registered outputs):
  - gnt_k=1, mem_en=1.
  - mem_we=pk_we; mem_addr=pk_addr and mem_wdata=pk_wdata, as sampled at the deciding edge.
  - The other port's gnt=0.
- In IDLE: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- Latency:
  - Request seen at edge N -> gnt and memory access during cycle N+1.
  - For a read, rvalid_k=1 during cycle N+2.
- rdata_k = mem_rdata when rvalid_k=1, else 0.
- Writes: no rvalid; write completes at the end of the GNT cycle.
- Throughput:
  - Alternating ports may be granted back-to-back every cycle.
  - A single port alone is granted at most every other cycle, because req is consumed the cycle it is granted.
- Simultaneous read on one port and grant to the other in the same cycle is legal: rvalid of the previous grant coincides with the new gnt.
- A requester dropping req before gnt withdraws the request; no error.
- Changing pk_we/addr/wdata while req is high without gnt is a protocol violation and its result is undefined.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRI_EN.
- Defined:
  - On contention, port 0 always wins.
  - Pointer logic is removed.
  - Port 1 is granted only when port 0 has no eligible request. This includes the cycle after a port 0 grant, so port 1 still progresses.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert rst 2 cycles with both req=1 -> all outputs 0. After release, first grant p0_gnt at cycle 2 post-reset.
- Single read:
  - Preload addr 5 = 8'hA7.
  - p0 read addr 5 at edge N -> cycle N+1: p0_gnt=1, mem_en=1, mem_we=0, mem_addr=5.
  - Cycle N+2: p0_rvalid=1, p0_rdata=8'hA7.
- Contention, round-robin:
  - Both ports request writes continuously: p0 addr 1 data 8'h11, p1 addr 2 data 8'h22.
  - Grants alternate p0, p1, p0, p1 every cycle.
  - Readback shows addr 1 = 8'h11 and addr 2 = 8'h22.
- Single-port throughput: p0 holds req with no p1 request -> p0_gnt pattern 1,0,1,0; mem_en duty 50%.
- Mid-operation reset: assert rst in the cycle p1 is granted a read of addr 3 -> p1_rvalid never asserts; memory contents unchanged.
- Fixed priority (DMEM_ARB_FIXED_PRI_EN):
  - Both ports request reads continuously -> sequence p0, p1, p0, p1.
  - With port 0 requesting continuously, port 1 is never starved beyond 1 cycle.
  - Without the macro, the same stimulus also alternates, but the first grant after reset goes to p0.
